// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM generator with per-frame jog/slew offset control
module servo_pwm_multi #(
    parameter int CHANNELS     = 4,
    parameter int PERIOD_TICKS = 20000,
    parameter int MIN_PULSE    = 400,
    parameter int MAX_OFFSET   = 2200,
    parameter int STEP         = 10,
    parameter int PW           = 12
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] dir,
    input  logic [CHANNELS-1:0] freeze,
    input  logic [CHANNELS-1:0] mode,
    input  logic                tgt_valid,
    input  logic [3:0]          tgt_ch,
    input  logic [PW-1:0]       tgt_value,
    output logic                tgt_ready,
    input  logic [3:0]          sel,
    output logic [PW-1:0]       pos_out,
    output logic [CHANNELS-1:0] at_target,
    output logic                frame_tick,
    output logic                tgt_err,
    output logic [CHANNELS-1:0] servo
);
    localparam int CW = $clog2(PERIOD_TICKS);
    localparam int XW = (CW > PW + 1) ? CW : PW + 1;
    localparam int PW1 = PW + 1;
    localparam logic [PW:0]   STEP_W = PW1'(STEP);
    localparam logic [PW:0]   MAX_W  = PW1'(MAX_OFFSET);
    localparam logic [PW:0]   MIN_W  = PW1'(MIN_PULSE);
    localparam logic [CW-1:0] LAST   = CW'(PERIOD_TICKS - 1);
    localparam logic [4:0]    NCH    = 5'(CHANNELS);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       offset_q [CHANNELS];
    logic [PW-1:0]       offset_d [CHANNELS];
    logic [PW-1:0]       target_q [CHANNELS];
    logic [PW-1:0]       target_d [CHANNELS];
    logic [PW:0]         thr      [CHANNELS];
    logic [CHANNELS-1:0] servo_q, servo_d;
    logic                frame_tick_q;
    logic                tgt_err_q, tgt_err_d;
    logic                xfer;
    logic [PW-1:0]       tgt_clamp;

    // Saturating step; all arithmetic is PW+1 bits so the result never wraps.
    function automatic logic [PW-1:0] next_off(input logic [PW:0] off, input logic [PW:0] tgt,
                                               input logic up, input logic slew);
        logic [PW:0] sum;
        logic [PW:0] gap;
        sum = off + STEP_W;
        if (slew) begin
            if (tgt > off) begin
                gap = tgt - off;
                return PW'(off + ((gap > STEP_W) ? STEP_W : gap));
            end
            gap = off - tgt;
            return PW'(off - ((gap > STEP_W) ? STEP_W : gap));
        end
        if (up)
            return PW'((sum > MAX_W) ? MAX_W : sum);
        return PW'((off > STEP_W) ? (off - STEP_W) : '0);
    endfunction

    assign tgt_ready = (cnt_q != '0);
    assign xfer      = tgt_valid && tgt_ready;
    assign tgt_clamp = ({1'b0, tgt_value} > MAX_W) ? MAX_W[PW-1:0] : tgt_value;

    always_comb begin
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        tgt_err_d = tgt_err_q | (xfer && ({1'b0, tgt_ch} >= NCH));
        servo_d   = '0;
        pos_out   = '0;
        at_target = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            offset_d[i] = offset_q[i];
            target_d[i] = target_q[i];
            if (cnt_q == '0 && !freeze[i])
                offset_d[i] = next_off({1'b0, offset_q[i]}, {1'b0, target_q[i]}, dir[i], mode[i]);
            if (xfer && tgt_ch == 4'(i))
                target_d[i] = tgt_clamp;
            thr[i]       = MIN_W + {1'b0, offset_q[i]};
            servo_d[i]   = XW'(cnt_q) < XW'(thr[i]);
            at_target[i] = (offset_q[i] == target_q[i]);
            if (sel == 4'(i))
                pos_out = offset_q[i];
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q        <= '0;
            servo_q      <= '0;
            frame_tick_q <= 1'b0;
            tgt_err_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                offset_q[i] <= '0;
                target_q[i] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            servo_q      <= servo_d;
            frame_tick_q <= (cnt_q == '0);
            tgt_err_q    <= tgt_err_d;
            for (int i = 0; i < CHANNELS; i++) begin
                offset_q[i] <= offset_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

    assign servo      = servo_q;
    assign frame_tick = frame_tick_q;
    assign tgt_err    = tgt_err_q;
endmodule
